// File: rtl/ibex_data_axi4l_bridge.sv
// ---------------------------------------------------------------------------
// ibex_data_axi4l_bridge
//
// Purpose:
//   Converts the Ibex core data port (req/gnt/rvalid) into AXI4-Lite master
//   transactions. One transaction is outstanding at a time; reads and writes
//   share a single FSM. The response goes back to the core as a registered,
//   one-cycle data_rvalid_o pulse.
//
// Optional feature (compile-time macro AXI4L_BRIDGE_TIMEOUT_EN):
//   When defined, the parameter TIMEOUT_CYCLES (default 256) is added. A
//   counter aborts any transaction that has been stuck in one busy state for
//   TIMEOUT_CYCLES cycles: the core gets an error response and the FSM goes to
//   DRAIN to swallow exactly one late B or R response. When undefined there
//   is no counter and no DRAIN state; the bridge waits indefinitely.
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   data_req_i/gnt_o       core request / grant (grant is combinational)
//   data_we_i, data_be_i   write enable, byte enables
//   data_addr_i/wdata_i    byte address, write data
//   data_rvalid_o          one-cycle response pulse
//   data_rdata_o           last read data (unchanged by writes)
//   data_err_o             response error, valid with data_rvalid_o
//   axi_aw*/axi_w*/axi_b*  AXI4-Lite write address / data / response channels
//   axi_ar*/axi_r*         AXI4-Lite read address / data channels
// ---------------------------------------------------------------------------
module ibex_data_axi4l_bridge
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic [31:0] axi_awaddr_o,
    output logic [2:0]  axi_awprot_o,
    output logic        axi_awvalid_o,
    input  logic        axi_awready_i,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wvalid_o,
    input  logic        axi_wready_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic        axi_bvalid_i,
    output logic        axi_bready_o,
    output logic [31:0] axi_araddr_o,
    output logic [2:0]  axi_arprot_o,
    output logic        axi_arvalid_o,
    input  logic        axi_arready_i,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i,
    input  logic        axi_rvalid_i,
    output logic        axi_rready_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
        , S_DRAIN
`endif
    } state_e;

    state_e      state_q, state_d;

    // Valid flags are registers of their own so that an aborted transaction
    // can keep an already-raised valid high until the slave takes it.
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q,  w_pend_d;
    logic        ar_pend_q, ar_pend_d;

    logic        rvalid_q,  rvalid_d;
    logic        err_q,     err_d;
    logic [31:0] rdata_q,   rdata_d;

    logic        latch_en;
    logic [31:2] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    logic        busy;

    assign busy = (state_q == S_WR_REQ)  || (state_q == S_WR_RESP) ||
                  (state_q == S_RD_REQ)  || (state_q == S_RD_RESP);

`ifdef AXI4L_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 256) ? 16 : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts cycles spent in the current busy state; any state change restarts it.
    assign cnt_d = (!busy || (state_d != state_q)) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        aw_pend_d    = aw_pend_q;
        w_pend_d     = w_pend_q;
        ar_pend_d    = ar_pend_q;
        rvalid_d     = 1'b0;
        err_d        = err_q;
        rdata_d      = rdata_q;
        latch_en     = 1'b0;
        data_gnt_o   = 1'b0;
        axi_bready_o = 1'b0;
        axi_rready_o = 1'b0;

        // Each request channel retires on its own handshake, whatever the state.
        if (aw_pend_q && axi_awready_i) aw_pend_d = 1'b0;
        if (w_pend_q  && axi_wready_i)  w_pend_d  = 1'b0;
        if (ar_pend_q && axi_arready_i) ar_pend_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_gnt_o = data_req_i;
                if (data_req_i) begin
                    latch_en = 1'b1;
                    if (data_we_i) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = S_WR_REQ;
                    end else begin
                        ar_pend_d = 1'b1;
                        state_d   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                // Uses the _d flags so AW and W finishing this cycle count.
                if (!aw_pend_d && !w_pend_d) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    rvalid_d = 1'b1;
                    err_d    = (axi_bresp_i != 2'b00);
                    state_d  = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (!ar_pend_d) state_d = S_RD_RESP;
            end
            S_RD_RESP: begin
                axi_rready_o = 1'b1;
                if (axi_rvalid_i) begin
                    rvalid_d = 1'b1;
                    err_d    = (axi_rresp_i != 2'b00);
                    rdata_d  = axi_rdata_i;
                    state_d  = S_IDLE;
                end
            end
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
            S_DRAIN: begin
                // Swallow the one late response of the aborted transaction.
                axi_bready_o = 1'b1;
                axi_rready_o = 1'b1;
                if (axi_bvalid_i || axi_rvalid_i) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef AXI4L_BRIDGE_TIMEOUT_EN
        // A response arriving in the last cycle wins over the abort.
        if (busy && (state_d == state_q) && (cnt_q == CNT_LAST)) begin
            state_d  = S_DRAIN;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            ar_pend_q <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            ar_pend_q <= ar_pend_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Request fields are captured at grant and held for the whole transaction.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (latch_en) begin
            addr_q  <= data_addr_i[31:2];
            be_q    <= data_be_i;
            wdata_q <= data_wdata_i;
        end
    end

    assign axi_awaddr_o  = {addr_q, 2'b00};
    assign axi_araddr_o  = {addr_q, 2'b00};
    assign axi_awprot_o  = 3'b000;
    assign axi_arprot_o  = 3'b000;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = be_q;
    assign axi_awvalid_o = aw_pend_q;
    assign axi_wvalid_o  = w_pend_q;
    assign axi_arvalid_o = ar_pend_q;

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_ibex_data_axi4l_bridge.sv
module tb_ibex_data_axi4l_bridge;

    localparam logic [31:0] ERR_ADDR = 32'h0000_0020;
    localparam logic [31:0] ERR_DATA = 32'hBAD0_0BAD;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = 4'h0;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] data_rdata;

    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic        axi_rvalid, axi_rready;

`ifdef AXI4L_BRIDGE_TIMEOUT_EN
    ibex_data_axi4l_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .axi_awaddr_o(axi_awaddr), .axi_awprot_o(axi_awprot), .axi_awvalid_o(axi_awvalid),
        .axi_awready_i(axi_awready), .axi_wdata_o(axi_wdata), .axi_wstrb_o(axi_wstrb),
        .axi_wvalid_o(axi_wvalid), .axi_wready_i(axi_wready), .axi_bresp_i(axi_bresp),
        .axi_bvalid_i(axi_bvalid), .axi_bready_o(axi_bready), .axi_araddr_o(axi_araddr),
        .axi_arprot_o(axi_arprot), .axi_arvalid_o(axi_arvalid), .axi_arready_i(axi_arready),
        .axi_rdata_i(axi_rdata), .axi_rresp_i(axi_rresp), .axi_rvalid_i(axi_rvalid),
        .axi_rready_o(axi_rready)
    );
`else
    ibex_data_axi4l_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .axi_awaddr_o(axi_awaddr), .axi_awprot_o(axi_awprot), .axi_awvalid_o(axi_awvalid),
        .axi_awready_i(axi_awready), .axi_wdata_o(axi_wdata), .axi_wstrb_o(axi_wstrb),
        .axi_wvalid_o(axi_wvalid), .axi_wready_i(axi_wready), .axi_bresp_i(axi_bresp),
        .axi_bvalid_i(axi_bvalid), .axi_bready_o(axi_bready), .axi_araddr_o(axi_araddr),
        .axi_arprot_o(axi_arprot), .axi_arvalid_o(axi_arvalid), .axi_arready_i(axi_arready),
        .axi_rdata_i(axi_rdata), .axi_rresp_i(axi_rresp), .axi_rvalid_i(axi_rvalid),
        .axi_rready_o(axi_rready)
    );
`endif

    int checks = 0;
    int failures = 0;

    int          aw_hold_cfg = 0;
    int          r_extra_cfg = 0;
    int          s_aw_stall;
    int          s_r_cnt;
    logic        s_r_armed, s_r_err, s_aw_got, s_w_got;
    logic [31:0] s_r_data, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_mem [0:255];
    logic [31:0] last_awaddr, last_araddr;
    logic [3:0]  last_wstrb;
    int          cyc = 0, rv_cnt = 0, b_hs_cnt = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
    logic        sl_aw, sl_w;
    logic [31:0] sl_a, sl_d;
    logic [3:0]  sl_s;

    assign axi_awready = (s_aw_stall >= aw_hold_cfg);
    assign axi_wready  = 1'b1;
    assign axi_arready = 1'b1;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (data_rvalid) rv_cnt <= rv_cnt + 1;
    end

    always @(posedge aclk) begin
        if (!aresetn) begin
            axi_bvalid <= 1'b0; axi_bresp <= 2'b00;
            axi_rvalid <= 1'b0; axi_rresp <= 2'b00; axi_rdata <= 32'h0;
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_r_armed <= 1'b0; s_aw_stall <= 0;
        end else begin
            sl_aw = s_aw_got; sl_a = s_awaddr;
            sl_w  = s_w_got;  sl_d = s_wdata; sl_s = s_wstrb;
            if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 1'b0;
                b_hs_cnt   <= b_hs_cnt + 1;
            end
            if (axi_awvalid && axi_awready) begin
                sl_aw = 1'b1; sl_a = axi_awaddr;
                last_awaddr <= axi_awaddr; aw_hs_cyc <= cyc; s_aw_stall <= 0;
            end else if (axi_awvalid) begin
                s_aw_stall <= s_aw_stall + 1;
            end
            if (axi_wvalid && axi_wready) begin
                sl_w = 1'b1; sl_d = axi_wdata; sl_s = axi_wstrb;
                last_wstrb <= axi_wstrb; w_hs_cyc <= cyc;
            end
            if (sl_aw && sl_w) begin
                for (int b = 0; b < 4; b++)
                    if (sl_s[b]) s_mem[sl_a[9:2]][8*b +: 8] = sl_d[8*b +: 8];
                axi_bvalid <= 1'b1; axi_bresp <= 2'b00;
                s_aw_got <= 1'b0; s_w_got <= 1'b0;
            end else begin
                s_aw_got <= sl_aw; s_awaddr <= sl_a;
                s_w_got <= sl_w; s_wdata <= sl_d; s_wstrb <= sl_s;
            end
            if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;
            if (axi_arvalid && axi_arready) begin
                last_araddr <= axi_araddr;
                if (r_extra_cfg == 0) begin
                    axi_rvalid <= 1'b1;
                    axi_rdata  <= (axi_araddr == ERR_ADDR) ? ERR_DATA : s_mem[axi_araddr[9:2]];
                    axi_rresp  <= (axi_araddr == ERR_ADDR) ? 2'b10 : 2'b00;
                end else begin
                    s_r_armed <= 1'b1;
                    s_r_cnt   <= r_extra_cfg - 1;
                    s_r_err   <= (axi_araddr == ERR_ADDR);
                    s_r_data  <= (axi_araddr == ERR_ADDR) ? ERR_DATA : s_mem[axi_araddr[9:2]];
                end
            end else if (s_r_armed) begin
                if (s_r_cnt == 0) begin
                    axi_rvalid <= 1'b1; axi_rdata <= s_r_data;
                    axi_rresp  <= s_r_err ? 2'b10 : 2'b00;
                    s_r_armed  <= 1'b0;
                end else begin
                    s_r_cnt <= s_r_cnt - 1;
                end
            end
        end
    end

    logic [31:0] ref_mem [0:255];
    logic [31:0] ref_last_rd = 32'h0;

    task automatic ref_apply(input logic we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] exp_rd,
                             output logic exp_err);
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
            exp_err = 1'b0;
        end else if ({addr[31:2], 2'b00} == ERR_ADDR) begin
            exp_err = 1'b1;
            ref_last_rd = ERR_DATA;
        end else begin
            exp_err = 1'b0;
            ref_last_rd = ref_mem[addr[9:2]];
        end
        exp_rd = ref_last_rd;
    endtask

    task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output int gwait, output int lat,
                          output logic [31:0] rd, output logic er, output logic extra);
        logic got;
        @(posedge aclk); #1;
        data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wdata;
        gwait = 0;
        @(negedge aclk);
        while (!data_gnt && gwait < 50) begin
            @(negedge aclk);
            gwait++;
        end
        @(posedge aclk); #1;
        data_req = 1'b0;
        lat = 0; got = 1'b0; rd = 32'hx; er = 1'bx; extra = 1'b0;
        while (!got && lat < 100) begin
            @(negedge aclk);
            lat++;
            if (data_rvalid) begin got = 1'b1; rd = data_rdata; er = data_err; end
        end
        if (!got) lat = -1;
        @(negedge aclk);
        extra = data_rvalid;
    endtask

    task automatic test_reset();
        data_req = 1'b0; aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, data_rvalid,
             data_err, data_gnt} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {axi_awvalid, axi_wvalid,
                     axi_arvalid, axi_bready, axi_rready, data_rvalid, data_err, data_gnt});
        end
        checks++;
        if (data_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata: got %h expected 00000000", data_rdata);
        end
        @(posedge aclk); #1; aresetn = 1'b1;
        $display("reset released");
    endtask

    task automatic test_write_read();
        int gw, lat; logic [31:0] rd, exp_rd; logic er, exp_er, ex;
        logic [31:0] wd [0:1];
        logic [3:0]  be [0:1];
        wd[0] = 32'hDEADBEEF; be[0] = 4'hF;
        wd[1] = 32'h0000AA00; be[1] = 4'h2;
        for (int i = 0; i < 2; i++) begin
            ref_apply(1'b1, be[i], 32'h10, wd[i], exp_rd, exp_er);
            do_txn(1'b1, be[i], 32'h10, wd[i], gw, lat, rd, er, ex);
            $display("write addr=00000010 be=%h data=%h lat=%0d err=%b", be[i], wd[i], lat, er);
            checks++;
            if (gw !== 0 || lat !== 3 || ex !== 1'b0) begin
                failures++; $display("FAIL wr_latency: got gwait=%0d lat=%0d extra=%b expected 0/3/0", gw, lat, ex);
            end
            checks++;
            if (er !== exp_er || rd !== exp_rd) begin
                failures++; $display("FAIL wr_resp: got err=%b rdata=%h expected err=%b rdata=%h", er, rd, exp_er, exp_rd);
            end
            checks++;
            if (last_awaddr !== 32'h10 || last_wstrb !== be[i]) begin
                failures++; $display("FAIL wr_axi: got awaddr=%h wstrb=%h expected 00000010 %h", last_awaddr, last_wstrb, be[i]);
            end
            ref_apply(1'b0, 4'hF, 32'h10, 32'h0, exp_rd, exp_er);
            do_txn(1'b0, 4'hF, 32'h10, 32'h0, gw, lat, rd, er, ex);
            $display("read addr=00000010 data=%h lat=%0d err=%b", rd, lat, er);
            checks++;
            if (lat !== 3 || rd !== exp_rd || er !== exp_er) begin
                failures++; $display("FAIL rd_data: got lat=%0d rdata=%h err=%b expected 3 %h %b", lat, rd, er, exp_rd, exp_er);
            end
            checks++;
            if (last_araddr !== 32'h10) begin
                failures++; $display("FAIL rd_araddr: got %h expected 00000010", last_araddr);
            end
        end
    endtask

    task automatic test_random();
        int gw, lat; logic [31:0] rd, exp_rd, a, d; logic er, exp_er, ex, we; logic [3:0] be;
        for (int i = 0; i < 24; i++) begin
            we = $urandom_range(0, 1);
            a  = ($urandom_range(0, 5) == 0) ? (ERR_ADDR | $urandom_range(0, 3))
                                             : (32'h100 + $urandom_range(0, 63));
            d  = $urandom; be = $urandom_range(0, 15);
            ref_apply(we, be, a, d, exp_rd, exp_er);
            do_txn(we, be, a, d, gw, lat, rd, er, ex);
            $display("rand %0d we=%b addr=%h be=%h rdata=%h err=%b lat=%0d", i, we, a, be, rd, er, lat);
            checks++;
            if (lat !== 3 || ex !== 1'b0 || rd !== exp_rd || er !== exp_er) begin
                failures++;
                $display("FAIL rand_resp: got lat=%0d extra=%b rdata=%h err=%b expected 3 0 %h %b", lat, ex, rd, er, exp_rd, exp_er);
            end
            checks++;
            if ((we ? last_awaddr : last_araddr) !== {a[31:2], 2'b00}) begin
                failures++;
                $display("FAIL rand_addr: got %h expected %h", we ? last_awaddr : last_araddr, {a[31:2], 2'b00});
            end
        end
    endtask

    task automatic test_aw_stall();
        int gw, lat, b0, r0; logic [31:0] rd, exp_rd; logic er, exp_er, ex;
        b0 = b_hs_cnt; r0 = rv_cnt;
        aw_hold_cfg = 3;
        ref_apply(1'b1, 4'h5, 32'h140, 32'h1234_5678, exp_rd, exp_er);
        do_txn(1'b1, 4'h5, 32'h140, 32'h1234_5678, gw, lat, rd, er, ex);
        aw_hold_cfg = 0;
        repeat (3) @(negedge aclk);
        $display("aw stall write lat=%0d w_cyc=%0d aw_cyc=%0d", lat, w_hs_cyc, aw_hs_cyc);
        checks++;
        if (!(w_hs_cyc < aw_hs_cyc) || lat !== 6 || er !== 1'b0) begin
            failures++; $display("FAIL aw_stall_order: got w=%0d aw=%0d lat=%0d err=%b expected w<aw lat=6 err=0", w_hs_cyc, aw_hs_cyc, lat, er);
        end
        checks++;
        if (b_hs_cnt - b0 !== 1 || rv_cnt - r0 !== 1) begin
            failures++; $display("FAIL aw_stall_count: got b=%0d rvalid=%0d expected 1 1", b_hs_cnt - b0, rv_cnt - r0);
        end
        ref_apply(1'b0, 4'hF, 32'h140, 32'h0, exp_rd, exp_er);
        do_txn(1'b0, 4'hF, 32'h140, 32'h0, gw, lat, rd, er, ex);
        checks++;
        if (rd !== exp_rd || er !== exp_er) begin
            failures++; $display("FAIL aw_stall_readback: got %h expected %h", rd, exp_rd);
        end
    endtask

    task automatic test_slverr();
        int gw, lat; logic [31:0] rd, exp_rd; logic er, exp_er, ex;
        ref_apply(1'b0, 4'hF, 32'h20, 32'h0, exp_rd, exp_er);
        do_txn(1'b0, 4'hF, 32'h20, 32'h0, gw, lat, rd, er, ex);
        $display("slverr read err=%b lat=%0d", er, lat);
        checks++;
        if (er !== 1'b1 || exp_er !== 1'b1 || lat !== 3 || ex !== 1'b0) begin
            failures++; $display("FAIL slverr: got err=%b lat=%0d extra=%b expected 1 3 0", er, lat, ex);
        end
        ref_apply(1'b0, 4'hF, 32'h10, 32'h0, exp_rd, exp_er);
        do_txn(1'b0, 4'hF, 32'h10, 32'h0, gw, lat, rd, er, ex);
        checks++;
        if (er !== 1'b0 || rd !== exp_rd) begin
            failures++; $display("FAIL slverr_recover: got err=%b rdata=%h expected 0 %h", er, rd, exp_rd);
        end
    endtask

    typedef struct { logic [31:0] rd; logic er; } exp_t;

    task automatic test_back_to_back();
        localparam int N = 12;
        logic        t_we [N];
        logic [3:0]  t_be [N];
        logic [31:0] t_a [N], t_d [N];
        exp_t        q [$];
        exp_t        e;
        int issued = 0, done = 0, n = 0, b0, nwr = 0;
        for (int i = 0; i < N; i++) begin
            t_we[i] = (i % 3 != 2) ? $urandom_range(0, 1) : 1'b0;
            t_a[i]  = 32'h180 + 4 * $urandom_range(0, 3);
            t_be[i] = $urandom_range(1, 15); t_d[i] = $urandom;
            if (t_we[i]) nwr++;
        end
        b0 = b_hs_cnt;
        @(posedge aclk); #1;
        data_req = 1'b1; data_we = t_we[0]; data_be = t_be[0]; data_addr = t_a[0]; data_wdata = t_d[0];
        while ((issued < N || done < issued) && n < 300) begin
            @(negedge aclk);
            n++;
            if (data_rvalid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL b2b_extra: got unexpected rvalid expected none");
                end else begin
                    e = q.pop_front();
                    $display("b2b resp %0d rdata=%h err=%b", done, data_rdata, data_err);
                    if (data_rdata !== e.rd || data_err !== e.er) begin
                        failures++; $display("FAIL b2b_resp: got %h/%b expected %h/%b", data_rdata, data_err, e.rd, e.er);
                    end
                end
                done++;
            end
            if (data_gnt && issued < N) begin
                if (issued > 0) begin
                    checks++;
                    if (data_rvalid !== 1'b1) begin
                        failures++; $display("FAIL b2b_gnt_timing: got rvalid=%b at gnt expected 1", data_rvalid);
                    end
                end
                ref_apply(t_we[issued], t_be[issued], t_a[issued], t_d[issued], e.rd, e.er);
                q.push_back(e);
                issued++;
            end
            @(posedge aclk); #1;
            if (issued < N) begin
                data_we = t_we[issued]; data_be = t_be[issued];
                data_addr = t_a[issued]; data_wdata = t_d[issued];
            end else begin
                data_req = 1'b0;
            end
        end
        data_req = 1'b0;
        repeat (2) @(negedge aclk);
        checks++;
        if (done !== N || q.size() !== 0 || b_hs_cnt - b0 !== nwr) begin
            failures++; $display("FAIL b2b_count: got done=%0d pending=%0d b=%0d expected %0d 0 %0d", done, q.size(), b_hs_cnt - b0, N, nwr);
        end
    endtask

    task automatic test_reset_mid();
        int gw, lat, r0, n = 0; logic [31:0] rd, exp_rd; logic er, exp_er, ex;
        r_extra_cfg = 20; r0 = rv_cnt;
        @(posedge aclk); #1;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h104;
        @(negedge aclk);
        while (!data_gnt && n < 20) begin @(negedge aclk); n++; end
        @(posedge aclk); #1; data_req = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if (axi_rready !== 1'b1) begin
            failures++; $display("FAIL mid_in_rd_resp: got rready=%b expected 1", axi_rready);
        end
        @(posedge aclk); #1; aresetn = 1'b0; r_extra_cfg = 0;
        @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, data_rvalid, data_err} !== 7'h00
            || data_rdata !== 32'h0) begin
            failures++; $display("FAIL mid_reset: got ctrl=%b rdata=%h expected 0000000 00000000",
                {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, data_rvalid, data_err}, data_rdata);
        end
        ref_last_rd = 32'h0;
        @(posedge aclk); #1; aresetn = 1'b1;
        ref_apply(1'b0, 4'hF, 32'h104, 32'h0, exp_rd, exp_er);
        do_txn(1'b0, 4'hF, 32'h104, 32'h0, gw, lat, rd, er, ex);
        $display("after mid reset read rdata=%h lat=%0d", rd, lat);
        checks++;
        if (rd !== exp_rd || lat !== 3 || rv_cnt - r0 !== 1) begin
            failures++; $display("FAIL mid_reset_recover: got %h lat=%0d pulses=%0d expected %h 3 1", rd, lat, rv_cnt - r0, exp_rd);
        end
    endtask

`ifdef AXI4L_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int gw, lat, r0; logic [31:0] rd, exp_rd, prev; logic er, exp_er, ex;
        prev = ref_last_rd; r0 = rv_cnt;
        r_extra_cfg = 12;
        do_txn(1'b0, 4'hF, 32'h100, 32'h0, gw, lat, rd, er, ex);
        r_extra_cfg = 0;
        $display("timeout read lat=%0d err=%b rdata=%h", lat, er, rd);
        checks++;
        if (lat !== 10 || er !== 1'b1 || rd !== prev || ex !== 1'b0) begin
            failures++; $display("FAIL timeout_resp: got lat=%0d err=%b rdata=%h extra=%b expected 10 1 %h 0", lat, er, rd, ex, prev);
        end
        ref_apply(1'b0, 4'hF, 32'h144, 32'h0, exp_rd, exp_er);
        do_txn(1'b0, 4'hF, 32'h144, 32'h0, gw, lat, rd, er, ex);
        $display("post drain read gwait=%0d rdata=%h", gw, rd);
        checks++;
        if (gw !== 3 || lat !== 3 || rd !== exp_rd || er !== 1'b0 || rv_cnt - r0 !== 2) begin
            failures++; $display("FAIL timeout_drain: got gwait=%0d lat=%0d rdata=%h err=%b pulses=%0d expected 3 3 %h 0 2",
                gw, lat, rd, er, rv_cnt - r0, exp_rd);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h0;
            s_mem[i]   = 32'h0;
        end
        test_reset();
        test_write_read();
        test_random();
        test_aw_stall();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
